// File: rtl/fxp_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fxp_pkg
//  Description : Shared constants and helpers for the fixed-point complex
//                multiplier: saturation limits, round offset and the
//                default-width complex sample type.
//  Revision    : 1.0 - initial release
// ============================================================================
package fxp_pkg;

  localparam int unsigned FXP_N_DEFAULT = 16;
  localparam int unsigned FXP_Q_DEFAULT = 9;

  // Complex sample at the default width.
  typedef struct packed {
    logic signed [FXP_N_DEFAULT-1:0] re;
    logic signed [FXP_N_DEFAULT-1:0] im;
  } fxp_cplx_t;

  // Largest positive N-bit two's-complement value (low N bits are valid).
  function automatic logic [63:0] fxp_max(input int unsigned n);
    return (64'd1 << (n - 1)) - 64'd1;
  endfunction

  // Most negative N-bit two's-complement value (low N bits are valid).
  function automatic logic [63:0] fxp_min(input int unsigned n);
    return ~fxp_max(n);
  endfunction

  // Constant added before the right shift: half an output LSB when
  // rounding, zero when truncating.
  function automatic logic [63:0] fxp_round_off(input int unsigned q, input bit rnd);
    return rnd ? (64'd1 << (q - 1)) : 64'd0;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fxp_cmult_pipe_if.sv
`default_nettype none
// ============================================================================
//  Module      : fxp_cmult_pipe_if
//  Description : Sample bus of the complex multiplier.
//                Upstream    : in_valid/in_ready, conj_b, a_re, a_im, b_re, b_im
//                Downstream  : out_valid/out_ready, p_re, p_im, ovf
//                Status      : ovf_sticky, ovf_clr
//                slave  = multiplier side, master = source/sink side.
//  Revision    : 1.0 - initial release
// ============================================================================
interface fxp_cmult_pipe_if
  import fxp_pkg::*;
#(
  parameter int N = FXP_N_DEFAULT
);

  logic                in_valid;
  logic                in_ready;
  logic                conj_b;
  logic signed [N-1:0] a_re;
  logic signed [N-1:0] a_im;
  logic signed [N-1:0] b_re;
  logic signed [N-1:0] b_im;
  logic                out_valid;
  logic                out_ready;
  logic signed [N-1:0] p_re;
  logic signed [N-1:0] p_im;
  logic                ovf;
  logic                ovf_sticky;
  logic                ovf_clr;

  modport master (
    output in_valid, conj_b, a_re, a_im, b_re, b_im, out_ready, ovf_clr,
    input  in_ready, out_valid, p_re, p_im, ovf, ovf_sticky
  );

  modport slave (
    input  in_valid, conj_b, a_re, a_im, b_re, b_im, out_ready, ovf_clr,
    output in_ready, out_valid, p_re, p_im, ovf, ovf_sticky
  );

endinterface
`default_nettype wire

// File: rtl/fxp_round_sat.sv
`default_nettype none
// ============================================================================
//  Module      : fxp_round_sat
//  Description : Scales a 2N+1-bit fixed-point value down by Q fractional
//                bits with optional round-half-up, then saturates or wraps
//                into N bits. Purely combinational.
//  Ports       : x   - 2N+1-bit signed input
//                y   - N-bit signed result
//                ovf - shifted value did not fit in N bits
//  Revision    : 1.0 - initial release
// ============================================================================
module fxp_round_sat
  import fxp_pkg::*;
#(
  parameter int N     = FXP_N_DEFAULT,
  parameter int Q     = FXP_Q_DEFAULT,
  parameter int ROUND = 1,
  parameter int SAT   = 1
) (
  input  logic signed [2*N:0]  x,
  output logic signed [N-1:0]  y,
  output logic                 ovf
);

  localparam int W = 2 * N + 1;
  localparam logic [63:0] C_OFF64 = fxp_round_off(Q, ROUND != 0);
  localparam logic [W-1:0] C_OFF = W'(C_OFF64);

  logic signed [W-1:0] w_t;
  logic signed [W-1:0] w_sh;
  logic [W-N:0]        w_hi;

  // The largest |x| reachable from N-bit operands is 2^(2N-1), so adding a
  // sub-LSB offset cannot overflow W bits.
  assign w_t  = x + $signed(C_OFF);
  assign w_sh = w_t >>> Q;

  // The result fits in N bits exactly when every bit from the N-bit sign
  // position upward is a copy of the sign.
  assign w_hi = w_sh[W-1:N-1];
  assign ovf  = !((&w_hi) || !(|w_hi));

  generate
    if (SAT != 0) begin : g_sat
      localparam logic [63:0] C_MAX64 = fxp_max(N);
      localparam logic [63:0] C_MIN64 = fxp_min(N);
      localparam logic [N-1:0] C_MAX = C_MAX64[N-1:0];
      localparam logic [N-1:0] C_MIN = C_MIN64[N-1:0];
      assign y = ovf ? (w_sh[W-1] ? $signed(C_MIN) : $signed(C_MAX)) : w_sh[N-1:0];
    end else begin : g_wrap
      assign y = w_sh[N-1:0];
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/fxp_cmult_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : fxp_cmult_pipe
//  Description : Four-stage pipelined two's-complement complex multiplier,
//                P = A*B or A*conj(B) per sample, Qm.Q operands, selectable
//                rounding/saturation, per-sample and sticky overflow.
//  Ports       : clk   - rising-edge clock
//                rst_n - asynchronous active-low reset
//                bus   - sample bus (slave modport): input handshake and
//                        operands, output handshake and result, overflow
//                        status and sticky-clear
//  Revision    : 1.0 - initial release
// ============================================================================
module fxp_cmult_pipe
  import fxp_pkg::*;
#(
  parameter int N     = FXP_N_DEFAULT,
  parameter int Q     = FXP_Q_DEFAULT,
  parameter int ROUND = 1,
  parameter int SAT   = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  fxp_cmult_pipe_if.slave   bus
);

  typedef struct packed {
    logic signed [N-1:0] re;
    logic signed [N-1:0] im;
  } cplx_n_t;

  // Full-precision signed product; operands are sign-extended first so the
  // multiply is carried out at 2N bits.
  function automatic logic signed [2*N-1:0] smul(
    input logic signed [N-1:0] x,
    input logic signed [N-1:0] y
  );
    logic signed [2*N-1:0] xe;
    logic signed [2*N-1:0] ye;
    xe = {{N{x[N-1]}}, x};
    ye = {{N{y[N-1]}}, y};
    return xe * ye;
  endfunction

  // Stage valid bits
  logic r_v1, r_v2, r_v3, r_v4;

  // S1: operands
  cplx_n_t r_a;
  cplx_n_t r_b;
  logic    r_cj1;

  // S2: partial products
  logic signed [2*N-1:0] r_rr, r_ii, r_ri, r_ir;
  logic                  r_cj2;

  // S3: combined real/imag at 2N+1 bits
  logic signed [2*N:0] r_re3, r_im3;

  // S4: output registers
  logic signed [N-1:0] r_p_re, r_p_im;
  logic                r_ovf;
  logic                r_sticky;

  logic                w_en;
  logic signed [2*N:0] w_rr, w_ii, w_ri, w_ir;
  logic signed [2*N:0] w_re, w_im;
  logic signed [N-1:0] w_re_rs, w_im_rs;
  logic                w_ovf_re, w_ovf_im;

  // One global enable: the whole pipe, bubbles included, freezes while a
  // result waits at the output. in_ready is therefore a combinational
  // function of out_ready.
  assign w_en = !(r_v4 && !bus.out_ready);

  // S3 combine. conj(B) is formed by swapping the add/subtract roles rather
  // than negating b_im, so a b_im of -2^(N-1) never needs an extra bit.
  always_comb begin
    w_rr = {r_rr[2*N-1], r_rr};
    w_ii = {r_ii[2*N-1], r_ii};
    w_ri = {r_ri[2*N-1], r_ri};
    w_ir = {r_ir[2*N-1], r_ir};
    if (r_cj2) begin
      w_re = w_rr + w_ii;
      w_im = w_ir - w_ri;
    end else begin
      w_re = w_rr - w_ii;
      w_im = w_ri + w_ir;
    end
  end

  fxp_round_sat #(
    .N     (N),
    .Q     (Q),
    .ROUND (ROUND),
    .SAT   (SAT)
  ) u_rs_re (
    .x   (r_re3),
    .y   (w_re_rs),
    .ovf (w_ovf_re)
  );

  fxp_round_sat #(
    .N     (N),
    .Q     (Q),
    .ROUND (ROUND),
    .SAT   (SAT)
  ) u_rs_im (
    .x   (r_im3),
    .y   (w_im_rs),
    .ovf (w_ovf_im)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v1   <= 1'b0;
      r_v2   <= 1'b0;
      r_v3   <= 1'b0;
      r_v4   <= 1'b0;
      r_a    <= '0;
      r_b    <= '0;
      r_cj1  <= 1'b0;
      r_rr   <= '0;
      r_ii   <= '0;
      r_ri   <= '0;
      r_ir   <= '0;
      r_cj2  <= 1'b0;
      r_re3  <= '0;
      r_im3  <= '0;
      r_p_re <= '0;
      r_p_im <= '0;
      r_ovf  <= 1'b0;
    end else if (w_en) begin
      // S1
      r_v1   <= bus.in_valid;
      r_cj1  <= bus.conj_b;
      r_a.re <= bus.a_re;
      r_a.im <= bus.a_im;
      r_b.re <= bus.b_re;
      r_b.im <= bus.b_im;
      // S2
      r_v2   <= r_v1;
      r_cj2  <= r_cj1;
      r_rr   <= smul(r_a.re, r_b.re);
      r_ii   <= smul(r_a.im, r_b.im);
      r_ri   <= smul(r_a.re, r_b.im);
      r_ir   <= smul(r_a.im, r_b.re);
      // S3
      r_v3   <= r_v2;
      r_re3  <= w_re;
      r_im3  <= w_im;
      // S4
      r_v4   <= r_v3;
      r_p_re <= w_re_rs;
      r_p_im <= w_im_rs;
      r_ovf  <= w_ovf_re | w_ovf_im;
    end
  end

  // Sticky overflow: a transferred overflowing result beats a same-cycle clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sticky <= 1'b0;
    end else if (r_v4 && bus.out_ready && r_ovf) begin
      r_sticky <= 1'b1;
    end else if (bus.ovf_clr) begin
      r_sticky <= 1'b0;
    end
  end

  assign bus.in_ready   = w_en;
  assign bus.out_valid  = r_v4;
  assign bus.p_re       = r_p_re;
  assign bus.p_im       = r_p_im;
  assign bus.ovf        = r_ovf;
  assign bus.ovf_sticky = r_sticky;

endmodule
`default_nettype wire

// File: tb/tb_fxp_cmult_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fxp_cmult_pipe
//  Description : Self-checking bench for fxp_cmult_pipe. Two instances run
//                the same stimulus: dut_a with ROUND=1/SAT=1 and dut_b with
//                ROUND=0/SAT=0. Expected results come from a longint model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fxp_cmult_pipe;
  import fxp_pkg::*;

  typedef struct {
    fxp_cplx_t p;
    logic      ovf;
  } exp_t;

  typedef struct {
    exp_t a;
    exp_t b;
  } pair_t;

  logic clk = 1'b0;
  logic rst_n;
  bit   rand_rdy;
  int   checks = 0;
  int   errors = 0;

  pair_t sb[$];

  always #5 clk = ~clk;

  fxp_cmult_pipe_if #(.N(16)) bus_a ();
  fxp_cmult_pipe_if #(.N(16)) bus_b ();

  fxp_cmult_pipe #(.N(16), .Q(9), .ROUND(1), .SAT(1)) u_dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_a)
  );

  fxp_cmult_pipe #(.N(16), .Q(9), .ROUND(0), .SAT(0)) u_dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_b)
  );

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic signed [15:0] rs(input longint x, input bit rnd, input bit sat, output logic o);
    longint t;
    longint s;
    t = x + (rnd ? 64'sd256 : 64'sd0);
    s = t >>> 9;
    o = (s > 32767) || (s < -32768);
    if (o && sat) return (s < 0) ? 16'sh8000 : 16'sh7FFF;
    return s[15:0];
  endfunction

  function automatic exp_t model(input logic signed [15:0] ar, input logic signed [15:0] ai,
                                 input logic signed [15:0] br, input logic signed [15:0] bi,
                                 input logic cj, input bit rnd, input bit sat);
    longint rr, ii, ri, ir, re, im;
    logic   o_re, o_im;
    exp_t   e;
    rr = longint'(ar) * longint'(br);
    ii = longint'(ai) * longint'(bi);
    ri = longint'(ar) * longint'(bi);
    ir = longint'(ai) * longint'(br);
    re = cj ? (rr + ii) : (rr - ii);
    im = cj ? (ir - ri) : (ri + ir);
    e.p.re = rs(re, rnd, sat, o_re);
    e.p.im = rs(im, rnd, sat, o_im);
    e.ovf  = o_re | o_im;
    return e;
  endfunction

  // ---------------- drivers ----------------
  task automatic set_in(input logic v, input logic signed [15:0] ar, input logic signed [15:0] ai,
                        input logic signed [15:0] br, input logic signed [15:0] bi, input logic cj);
    bus_a.in_valid = v; bus_a.a_re = ar; bus_a.a_im = ai; bus_a.b_re = br; bus_a.b_im = bi; bus_a.conj_b = cj;
    bus_b.in_valid = v; bus_b.a_re = ar; bus_b.a_im = ai; bus_b.b_re = br; bus_b.b_im = bi; bus_b.conj_b = cj;
  endtask

  task automatic set_rdy(input logic r);
    bus_a.out_ready = r;
    bus_b.out_ready = r;
  endtask

  task automatic set_clr(input logic c);
    bus_a.ovf_clr = c;
    bus_b.ovf_clr = c;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_rdy) set_rdy($urandom_range(0, 3) != 0);
  endtask

  task automatic drain(input int n);
    repeat (n) tick();
  endtask

  task automatic send(input logic signed [15:0] ar, input logic signed [15:0] ai,
                      input logic signed [15:0] br, input logic signed [15:0] bi, input logic cj);
    pair_t pr;
    int    guard;
    guard = 0;
    pr.a = model(ar, ai, br, bi, cj, 1'b1, 1'b1);
    pr.b = model(ar, ai, br, bi, cj, 1'b0, 1'b0);
    set_in(1'b1, ar, ai, br, bi, cj);
    @(negedge clk);
    while (!bus_a.in_ready && guard < 200) begin
      tick();
      @(negedge clk);
      guard++;
    end
    if (guard >= 200) chk("send_timeout", bus_a.in_ready, 1);
    else sb.push_back(pr);
    tick();
    set_in(1'b0, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 1'b0);
  endtask

  task automatic latency_check(input string tag);
    int lat;
    lat = 0;
    while (!bus_a.out_valid && lat < 12) begin
      @(negedge clk);
      lat++;
    end
    chk(tag, lat, 4);
  endtask

  // ---------------- output monitor / scoreboard ----------------
  logic            stall_prev;
  logic [15:0]     prev_re_a, prev_im_a, prev_re_b, prev_im_b;
  logic            prev_ovf_a, prev_ovf_b;
  logic            exp_sticky_a, exp_sticky_b;

  always @(negedge clk) begin
    pair_t e;
    logic  set_a, set_b;
    if (!rst_n) begin
      stall_prev   = 1'b0;
      exp_sticky_a = 1'b0;
      exp_sticky_b = 1'b0;
    end else begin
      set_a = 1'b0;
      set_b = 1'b0;
      chk("in_ready_a", bus_a.in_ready, !(bus_a.out_valid && !bus_a.out_ready));
      chk("in_ready_b", bus_b.in_ready, !(bus_b.out_valid && !bus_b.out_ready));
      chk("sticky_a", bus_a.ovf_sticky, exp_sticky_a);
      chk("sticky_b", bus_b.ovf_sticky, exp_sticky_b);
      if (stall_prev) begin
        chk("hold_valid_a", bus_a.out_valid, 1);
        chk("hold_re_a", bus_a.p_re, $signed(prev_re_a));
        chk("hold_im_a", bus_a.p_im, $signed(prev_im_a));
        chk("hold_ovf_a", bus_a.ovf, prev_ovf_a);
        chk("hold_valid_b", bus_b.out_valid, 1);
        chk("hold_re_b", bus_b.p_re, $signed(prev_re_b));
        chk("hold_im_b", bus_b.p_im, $signed(prev_im_b));
        chk("hold_ovf_b", bus_b.ovf, prev_ovf_b);
      end
      if (bus_a.out_valid && bus_a.out_ready) begin
        if (sb.size() == 0) begin
          chk("spurious_out_a", bus_a.out_valid, 0);
        end else begin
          e = sb.pop_front();
          chk("p_re_a", bus_a.p_re, e.a.p.re);
          chk("p_im_a", bus_a.p_im, e.a.p.im);
          chk("ovf_a", bus_a.ovf, e.a.ovf);
          chk("valid_b", bus_b.out_valid, 1);
          chk("p_re_b", bus_b.p_re, e.b.p.re);
          chk("p_im_b", bus_b.p_im, e.b.p.im);
          chk("ovf_b", bus_b.ovf, e.b.ovf);
          set_a = e.a.ovf;
          set_b = e.b.ovf;
        end
      end
      if (set_a) exp_sticky_a = 1'b1;
      else if (bus_a.ovf_clr) exp_sticky_a = 1'b0;
      if (set_b) exp_sticky_b = 1'b1;
      else if (bus_b.ovf_clr) exp_sticky_b = 1'b0;
      stall_prev = bus_a.out_valid && !bus_a.out_ready;
      prev_re_a  = bus_a.p_re;
      prev_im_a  = bus_a.p_im;
      prev_ovf_a = bus_a.ovf;
      prev_re_b  = bus_b.p_re;
      prev_im_b  = bus_b.p_im;
      prev_ovf_b = bus_b.ovf;
    end
  end

  // ---------------- directed sequence ----------------
  initial begin
    rst_n    = 1'b0;
    rand_rdy = 1'b0;
    set_in(1'b0, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 1'b0);
    set_rdy(1'b1);
    set_clr(1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid_a", bus_a.out_valid, 0);
    chk("rst_p_re_a", bus_a.p_re, 0);
    chk("rst_p_im_a", bus_a.p_im, 0);
    chk("rst_ovf_a", bus_a.ovf, 0);
    chk("rst_sticky_a", bus_a.ovf_sticky, 0);
    chk("rst_in_ready_a", bus_a.in_ready, 1);
    chk("rst_valid_b", bus_b.out_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    drain(2);

    // Real product and pipeline latency
    send(16'sd1280, 16'sd0, 16'sd3200, 16'sd0, 1'b0);
    latency_check("latency");
    drain(2);

    // Complex products, saturation, rounding boundaries, extreme operands
    send(16'sd1280, 16'sd512, 16'sd512, -16'sd256, 1'b0);
    send(16'sd1280, 16'sd512, 16'sd512, -16'sd256, 1'b1);
    send(16'sd20480, 16'sd0, 16'sd20480, 16'sd0, 1'b0);
    send(16'sd1, 16'sd0, 16'sd256, 16'sd0, 1'b0);
    send(-16'sd1, 16'sd0, 16'sd256, 16'sd0, 1'b0);
    send(-16'sd32768, 16'sd0, 16'sd0, -16'sd32768, 1'b1);
    send(-16'sd32768, 16'sd0, 16'sd0, -16'sd32768, 1'b0);
    send(-16'sd32768, -16'sd32768, -16'sd32768, -16'sd32768, 1'b0);
    send(-16'sd32768, -16'sd32768, -16'sd32768, -16'sd32768, 1'b1);
    drain(8);
    chk("sticky_set_a", bus_a.ovf_sticky, 1);
    chk("sticky_set_b", bus_b.ovf_sticky, 1);

    // Clear the sticky flag
    set_clr(1'b1);
    tick();
    set_clr(1'b0);
    tick();
    chk("sticky_clr_a", bus_a.ovf_sticky, 0);
    chk("sticky_clr_b", bus_b.ovf_sticky, 0);

    // Clear held high while an overflowing result transfers
    set_clr(1'b1);
    send(16'sd20480, 16'sd0, 16'sd20480, 16'sd0, 1'b0);
    drain(6);
    set_clr(1'b0);
    drain(2);

    // Output stall: result must hold and in_ready must drop
    set_rdy(1'b0);
    send(16'sd1280, 16'sd512, 16'sd512, -16'sd256, 1'b0);
    drain(6);
    chk("stall_in_ready", bus_a.in_ready, 0);
    chk("stall_valid", bus_a.out_valid, 1);
    set_rdy(1'b1);
    drain(3);

    // Random stream with random backpressure
    rand_rdy = 1'b1;
    for (int i = 0; i < 20; i++) begin
      send(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), 1'($urandom));
    end
    rand_rdy = 1'b0;
    set_rdy(1'b1);
    drain(12);
    chk("sb_empty_random", sb.size(), 0);

    // Reset with samples in flight
    for (int i = 0; i < 4; i++) begin
      send(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), 1'($urandom));
    end
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid_a", bus_a.out_valid, 0);
    chk("mid_rst_p_re_a", bus_a.p_re, 0);
    chk("mid_rst_p_im_a", bus_a.p_im, 0);
    chk("mid_rst_ovf_a", bus_a.ovf, 0);
    chk("mid_rst_sticky_a", bus_a.ovf_sticky, 0);
    chk("mid_rst_valid_b", bus_b.out_valid, 0);
    sb.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    drain(6);
    chk("no_stale_valid", bus_a.out_valid, 0);
    send(16'sd1280, 16'sd0, 16'sd3200, 16'sd0, 1'b0);
    latency_check("latency_after_rst");
    drain(4);
    chk("sb_empty_final", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
